// File: rtl/sram_rd_sequencer_pkg.sv
// Shared global-buffer definitions: default widths, sequencer state encoding
// and the start-time configuration record.
package sram_rd_sequencer_pkg;

  localparam int GB_ID_W   = 4;
  localparam int GB_DATA_W = 8;
  localparam int GB_CYC_W  = 8;
  localparam int GB_ADDR_W = 10;
  localparam int GB_OUT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } gb_state_e;

  typedef struct packed {
    logic [GB_ID_W:0]     bank_num;
    logic [GB_ID_W-1:0]   start_bank;
    logic [GB_DATA_W-1:0] data_num;
    logic [GB_CYC_W-1:0]  cyc_num;
    logic [GB_ADDR_W-1:0] base_addr;
  } gb_cfg_t;

endpackage

// File: rtl/sram_rd_sequencer_outstanding.sv
// Up/down counter of SRAM reads in flight, with full/empty flags.
// A decrement while empty is dropped so stray responses cannot underflow.
module gb_outstanding_cnt #(
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [OUT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  logic inc_ok;
  logic dec_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == '1);
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & ~empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + OUT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - OUT_W'(1);
    end
  end

endmodule

// File: rtl/sram_rd_sequencer.sv
// Read-ID/address sequencer: walks a block round-robin across GB banks for
// cfg_cyc_num passes, with rewind, backpressure and outstanding-read drain.
module sram_rd_sequencer
  import sram_rd_sequencer_pkg::*;
#(
  parameter int ID_W   = GB_ID_W,
  parameter int DATA_W = GB_DATA_W,
  parameter int CYC_W  = GB_CYC_W,
  parameter int ADDR_W = GB_ADDR_W,
  parameter int OUT_W  = GB_OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ID_W:0]     cfg_bank_num,
  input  logic [ID_W-1:0]   cfg_start_bank,
  input  logic [DATA_W-1:0] cfg_data_num,
  input  logic [CYC_W-1:0]  cfg_cyc_num,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              pull_back,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ID_W-1:0]   rd_id,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_last,
  output logic [CYC_W-1:0]  rd_cyc,
  input  logic              rsp_valid,
  output logic              busy,
  output logic              done,
  output logic              err_cfg,
  output logic [CYC_W-1:0]  pb_cnt
);

  typedef struct packed {
    logic [ID_W:0]     bank_num;
    logic [ID_W-1:0]   start_bank;
    logic [DATA_W-1:0] data_num;
    logic [CYC_W-1:0]  cyc_num;
    logic [ADDR_W-1:0] base_addr;
  } cfg_t;

  localparam logic [ID_W:0] MAX_BANKS = {1'b1, {ID_W{1'b0}}};

  gb_state_e         state;
  cfg_t              cfg;
  logic [ID_W-1:0]   bank;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] item;
  logic [CYC_W-1:0]  cyc;

  logic [OUT_W-1:0]  out_cnt;
  logic              out_full;
  logic              out_empty;

  logic fire;
  logic item_last;
  logic cyc_last;
  logic bank_wrap;
  logic cfg_bad;
  logic drain_done;

  assign rd_valid  = (state == ST_RUN) & ~out_full & ~pull_back;
  assign fire      = rd_valid & rd_ready;
  assign item_last = (item == cfg.data_num - DATA_W'(1));
  assign cyc_last  = (cyc == cfg.cyc_num - CYC_W'(1));
  assign bank_wrap = ({1'b0, bank} == cfg.bank_num - (ID_W+1)'(1));

  assign rd_id   = bank;
  assign rd_addr = cfg.base_addr + row;
  assign rd_last = (state == ST_RUN) & item_last;
  assign rd_cyc  = cyc;
  assign busy    = (state != ST_IDLE);

  assign cfg_bad = (cfg_bank_num == '0) || (cfg_bank_num > MAX_BANKS) ||
                   ({1'b0, cfg_start_bank} >= cfg_bank_num) ||
                   (cfg_data_num == '0) || (cfg_cyc_num == '0);

  // Look one response ahead so done lands in the cycle after the final response.
  assign drain_done = out_empty | ((out_cnt == OUT_W'(1)) & rsp_valid);

  gb_outstanding_cnt #(
    .OUT_W(OUT_W)
  ) u_out_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (abort),
    .inc  (fire & ~abort),
    .dec  (rsp_valid),
    .cnt  (out_cnt),
    .full (out_full),
    .empty(out_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cfg     <= '0;
      bank    <= '0;
      row     <= '0;
      item    <= '0;
      cyc     <= '0;
      pb_cnt  <= '0;
      done    <= 1'b0;
      err_cfg <= 1'b0;
    end else begin
      done    <= 1'b0;
      err_cfg <= 1'b0;
      if (abort) begin
        state  <= ST_IDLE;
        bank   <= '0;
        row    <= '0;
        item   <= '0;
        cyc    <= '0;
        pb_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                err_cfg <= 1'b1;
              end else begin
                cfg    <= '{bank_num:   cfg_bank_num,
                            start_bank: cfg_start_bank,
                            data_num:   cfg_data_num,
                            cyc_num:    cfg_cyc_num,
                            base_addr:  cfg_base_addr};
                bank   <= cfg_start_bank;
                row    <= '0;
                item   <= '0;
                cyc    <= '0;
                pb_cnt <= '0;
                state  <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (pull_back) begin
              bank <= cfg.start_bank;
              row  <= '0;
              item <= '0;
              if (pb_cnt != '1) pb_cnt <= pb_cnt + CYC_W'(1);
            end else if (fire) begin
              if (item_last) begin
                if (cyc_last) begin
                  state <= ST_DRAIN;
                end else begin
                  cyc  <= cyc + CYC_W'(1);
                  bank <= cfg.start_bank;
                  row  <= '0;
                  item <= '0;
                end
              end else begin
                item <= item + DATA_W'(1);
                if (bank_wrap) begin
                  bank <= '0;
                  row  <= row + ADDR_W'(1);
                end else begin
                  bank <= bank + ID_W'(1);
                end
              end
            end
          end
          ST_DRAIN: begin
            if (drain_done) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_rd_sequencer.sv
// Self-checking bench: table of job configs with a scoreboard of expected
// read requests, plus directed rewind, abort and backpressure sequences.
module tb_sram_rd_sequencer;
  import sram_rd_sequencer_pkg::*;

  localparam int ID_W   = GB_ID_W;
  localparam int DATA_W = GB_DATA_W;
  localparam int CYC_W  = GB_CYC_W;
  localparam int ADDR_W = GB_ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, start2, abort, pull_back, rsp_valid2;
  logic              rd_ready  = 1'b1;
  logic              rsp_valid = 1'b0;
  logic [ID_W:0]     cfg_bank_num;
  logic [ID_W-1:0]   cfg_start_bank;
  logic [DATA_W-1:0] cfg_data_num;
  logic [CYC_W-1:0]  cfg_cyc_num;
  logic [ADDR_W-1:0] cfg_base_addr;

  logic              rd_valid, rd_last, busy, done, err_cfg;
  logic [ID_W-1:0]   rd_id;
  logic [ADDR_W-1:0] rd_addr;
  logic [CYC_W-1:0]  rd_cyc, pb_cnt;

  logic              rd_valid2, rd_last2, busy2, done2, err2;
  logic [ID_W-1:0]   rd_id2;
  logic [ADDR_W-1:0] rd_addr2;
  logic [CYC_W-1:0]  rd_cyc2, pb2;

  sram_rd_sequencer #(
    .ID_W(ID_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .ADDR_W(ADDR_W), .OUT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_bank_num(cfg_bank_num), .cfg_start_bank(cfg_start_bank),
    .cfg_data_num(cfg_data_num), .cfg_cyc_num(cfg_cyc_num),
    .cfg_base_addr(cfg_base_addr), .pull_back(pull_back),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_id(rd_id),
    .rd_addr(rd_addr), .rd_last(rd_last), .rd_cyc(rd_cyc),
    .rsp_valid(rsp_valid), .busy(busy), .done(done), .err_cfg(err_cfg),
    .pb_cnt(pb_cnt)
  );

  sram_rd_sequencer #(
    .OUT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort),
    .cfg_bank_num(cfg_bank_num), .cfg_start_bank(cfg_start_bank),
    .cfg_data_num(cfg_data_num), .cfg_cyc_num(cfg_cyc_num),
    .cfg_base_addr(cfg_base_addr), .pull_back(pull_back),
    .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_id(rd_id2),
    .rd_addr(rd_addr2), .rd_last(rd_last2), .rd_cyc(rd_cyc2),
    .rsp_valid(rsp_valid2), .busy(busy2), .done(done2), .err_cfg(err2),
    .pb_cnt(pb2)
  );

  typedef struct {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic [CYC_W-1:0]  cyc;
  } req_t;

  typedef struct {
    gb_cfg_t cfg;
    bit      exp_err;
    bit      rnd;
    int      exp_fires;
  } vec_t;

  req_t        exp_q[$];
  req_t        e;
  int unsigned due_q[$];
  int unsigned tick = 0;
  int unsigned last_rsp_tick = 0;
  int unsigned rsp_delay = 2;
  int          n_chk = 0, n_fail = 0;
  int          fires = 0, fires2 = 0, done_cnt = 0, err_cnt = 0;
  bit          sb_en = 1'b1, rdy_rand = 1'b0;
  vec_t        vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int bn, input int sb, input int dn, input int cn,
                              input int base, input bit err, input bit rnd, input int nf);
    vec_t v;
    v.cfg.bank_num   = (ID_W+1)'(bn);
    v.cfg.start_bank = ID_W'(sb);
    v.cfg.data_num   = DATA_W'(dn);
    v.cfg.cyc_num    = CYC_W'(cn);
    v.cfg.base_addr  = ADDR_W'(base);
    v.exp_err        = err;
    v.rnd            = rnd;
    v.exp_fires      = nf;
    return v;
  endfunction

  // Item i of a pass sits at linear slot start+i: bank = slot mod N, row = slot div N.
  task automatic push_pass(input gb_cfg_t c, input int cyc_idx, input int n_items);
    req_t r;
    int slot;
    for (int i = 0; i < n_items; i++) begin
      slot   = int'(c.start_bank) + i;
      r.id   = ID_W'(slot % int'(c.bank_num));
      r.addr = ADDR_W'(int'(c.base_addr) + slot / int'(c.bank_num));
      r.last = (i == int'(c.data_num) - 1);
      r.cyc  = CYC_W'(cyc_idx);
      exp_q.push_back(r);
    end
  endtask

  task automatic push_job(input gb_cfg_t c);
    for (int k = 0; k < int'(c.cyc_num); k++) push_pass(c, k, int'(c.data_num));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input gb_cfg_t c);
    cfg_bank_num   = c.bank_num;
    cfg_start_bank = c.start_bank;
    cfg_data_num   = c.data_num;
    cfg_cyc_num    = c.cyc_num;
    cfg_base_addr  = c.base_addr;
  endtask

  task automatic scramble_cfg();
    cfg_bank_num   = (ID_W+1)'($urandom);
    cfg_start_bank = ID_W'($urandom);
    cfg_data_num   = DATA_W'($urandom);
    cfg_cyc_num    = CYC_W'($urandom);
    cfg_base_addr  = ADDR_W'($urandom);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, busy, 0);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int f0, d0, e0;
    f0 = fires; d0 = done_cnt; e0 = err_cnt;
    rdy_rand = v.rnd;
    if (!v.exp_err) push_job(v.cfg);
    step(); drive_cfg(v.cfg); start = 1'b1;
    step(); start = 1'b0; scramble_cfg();
    @(negedge clk);
    if (v.exp_err) begin
      chk({tag, "_err_cfg"}, err_cfg, 1);
      chk({tag, "_busy"}, busy, 0);
      @(negedge clk);
      chk({tag, "_err_pulse"}, err_cfg, 0);
      chk({tag, "_busy_after"}, busy, 0);
    end else begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_cyc0"}, rd_cyc, 0);
      chk({tag, "_pb0"}, pb_cnt, 0);
      wait_idle(tag);
      @(negedge clk);
      chk({tag, "_fires"}, fires - f0, v.exp_fires);
      chk({tag, "_done"}, done_cnt - d0, 1);
      chk({tag, "_sb_left"}, exp_q.size(), 0);
      chk({tag, "_no_err"}, err_cnt - e0, 0);
    end
    rdy_rand = 1'b0;
  endtask

  always @(posedge clk) tick <= tick + 1;

  // Responder: one response per fire, rsp_delay cycles later; also drives rd_ready.
  always @(posedge clk) begin
    #1;
    rsp_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == tick) begin
      rsp_valid = 1'b1;
      void'(due_q.pop_front());
    end
    rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) last_rsp_tick = tick;
      if (rd_valid && rd_ready) begin
        fires++;
        due_q.push_back(tick + rsp_delay);
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_fire", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rd_id", rd_id, e.id);
            chk("rd_addr", rd_addr, e.addr);
            chk("rd_last", rd_last, e.last);
            chk("rd_cyc", rd_cyc, e.cyc);
          end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_lat", tick, last_rsp_tick + 1);
      end
      if (err_cfg) err_cnt++;
      if (rd_valid2 && rd_ready) fires2++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gb_cfg_t c;
    int f0, d0;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0; pull_back = 1'b0;
    rsp_valid2 = 1'b0;
    drive_cfg('0);

    vecs[0] = mk(4,  0,  6, 1, 'h010, 0, 0, 6);
    vecs[1] = mk(3,  2,  4, 2, 'h020, 0, 0, 8);
    vecs[2] = mk(4,  4,  6, 1, 'h000, 1, 0, 0);
    vecs[3] = mk(4,  0,  0, 1, 'h000, 1, 0, 0);
    vecs[4] = mk(16, 15, 20, 2, 'h3FF, 0, 1, 40);
    vecs[5] = mk(1,  0,  3, 3, 'h100, 0, 1, 9);
    vecs[6] = mk(0,  0,  1, 1, 'h000, 1, 0, 0);
    vecs[7] = mk(17, 0,  1, 1, 'h000, 1, 0, 0);
    vecs[8] = mk(2,  1,  1, 0, 'h000, 1, 0, 0);
    vecs[9] = mk(2,  1,  1, 1, 'h003, 0, 0, 1);

    repeat (3) step();
    @(negedge clk);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_cfg, 0);
    chk("rst_pb_cnt", pb_cnt, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_cyc", rd_cyc, 0);
    step(); rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 10; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // Rewind on the 3rd request of pass 1.
    c = vecs[0].cfg;
    c.bank_num = 5'd4; c.start_bank = 4'd1; c.data_num = 8'd5; c.cyc_num = 8'd3;
    c.base_addr = 10'h040;
    push_pass(c, 0, 5); push_pass(c, 1, 2); push_pass(c, 1, 5); push_pass(c, 2, 5);
    f0 = fires; d0 = done_cnt;
    step(); drive_cfg(c); start = 1'b1;
    step(); start = 1'b0;
    for (int n = 0; n < 100 && fires < f0 + 7; n++) @(posedge clk);
    #1;
    chk("pb_pre_fires", fires - f0, 7);
    pull_back = 1'b1;
    @(negedge clk);
    chk("pb_mask", rd_valid, 0);
    step(); pull_back = 1'b0;
    @(negedge clk);
    chk("pb_cnt", pb_cnt, 1);
    chk("pb_cyc", rd_cyc, 1);
    wait_idle("pb");
    @(negedge clk);
    chk("pb_fires", fires - f0, 17);
    chk("pb_done", done_cnt - d0, 1);
    chk("pb_sb_left", exp_q.size(), 0);
    step(); pull_back = 1'b1;
    step(); pull_back = 1'b0;
    @(negedge clk);
    chk("pb_idle_ignored", pb_cnt, 1);
    chk("pb_idle_busy", busy, 0);

    // Abort mid-RUN after a rewind.
    sb_en = 1'b0;
    c.bank_num = 5'd2; c.start_bank = 4'd0; c.data_num = 8'd8; c.cyc_num = 8'd2;
    f0 = fires; d0 = done_cnt;
    step(); drive_cfg(c); start = 1'b1;
    step(); start = 1'b0;
    for (int n = 0; n < 100 && fires < f0 + 3; n++) @(posedge clk);
    #1; pull_back = 1'b1;
    step(); pull_back = 1'b0;
    for (int n = 0; n < 100 && fires < f0 + 5; n++) @(posedge clk);
    #1; abort = 1'b1;
    @(negedge clk);
    chk("abort_run_pb", pb_cnt, 1);
    chk("abort_run_busy_pre", busy, 1);
    step(); abort = 1'b0;
    @(negedge clk);
    chk("abort_run_busy", busy, 0);
    repeat (6) step();
    chk("abort_run_no_done", done_cnt - d0, 0);
    exp_q.delete();
    sb_en = 1'b1;
    run_job(vecs[1], "restart1");

    // Abort while draining slow responses.
    rsp_delay = 12;
    c.bank_num = 5'd4; c.start_bank = 4'd0; c.data_num = 8'd2; c.cyc_num = 8'd1;
    push_job(c);
    f0 = fires; d0 = done_cnt;
    step(); drive_cfg(c); start = 1'b1;
    step(); start = 1'b0;
    for (int n = 0; n < 100 && fires < f0 + 2; n++) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", busy, 1);
    chk("drain_no_valid", rd_valid, 0);
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    @(negedge clk);
    chk("abort_drain_busy", busy, 0);
    repeat (16) step();
    chk("abort_drain_no_done", done_cnt - d0, 0);
    chk("abort_drain_sb_left", exp_q.size(), 0);
    rsp_delay = 2;
    run_job(vecs[0], "restart2");

    // Outstanding limit on the OUT_W=2 instance.
    c.bank_num = 5'd4; c.start_bank = 4'd0; c.data_num = 8'd10; c.cyc_num = 8'd1;
    f0 = fires2;
    step(); drive_cfg(c); start2 = 1'b1;
    step(); start2 = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("out_full_fires", fires2 - f0, 3);
    chk("out_full_valid", rd_valid2, 0);
    step(); rsp_valid2 = 1'b1;
    @(negedge clk);
    chk("out_rsp_cycle_valid", rd_valid2, 0);
    step(); rsp_valid2 = 1'b0;
    @(negedge clk);
    chk("out_one_more_valid", rd_valid2, 1);
    step();
    @(negedge clk);
    chk("out_refull_valid", rd_valid2, 0);
    chk("out_refull_fires", fires2 - f0, 4);
    step(); rsp_valid2 = 1'b1;
    step();
    @(negedge clk);
    chk("out_simul_valid", rd_valid2, 1);
    step(); rsp_valid2 = 1'b0;
    @(negedge clk);
    chk("out_simul_keep", rd_valid2, 1);
    step();
    @(negedge clk);
    chk("out_final_valid", rd_valid2, 0);
    chk("out_final_fires", fires2 - f0, 6);
    step(); abort = 1'b1;
    step(); abort = 1'b0;
    @(negedge clk);
    chk("out_abort_busy", busy2, 0);
    chk("out_no_done", done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
